uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 98 +++++++++
 tb/tb_uart_tx_frame.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one stop bit.
// Ports: i_clk bit clock, i_rst async reset, i_data/i_data_valid/i_par_en/i_par_typ request, o_tx_out line, o_busy.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_data_valid,
   input  logic                  i_par_en,
   input  logic                  i_par_typ,
   output logic                  o_tx_out,
   output logic                  o_busy
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]            state;
   logic [DATA_WIDTH-1:0] shift;
   logic [CW-1:0]         count;
   logic                  par_en;
   logic                  par_bit;

   // Outputs are registered one state ahead: each edge loads the line
   // value belonging to the state being entered.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         shift    <= '0;
         count    <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         o_tx_out <= 1'b1;
         o_busy   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_data_valid) begin
                  shift    <= i_data;
                  par_en   <= i_par_en;
                  // even: XOR of data; odd: its inverse
                  par_bit  <= (^i_data) ^ i_par_typ;
                  state    <= START;
                  o_tx_out <= 1'b0;
                  o_busy   <= 1'b1;
               end else begin
                  o_tx_out <= 1'b1;
                  o_busy   <= 1'b0;
               end
            end
            START: begin
               o_tx_out <= shift[0];
               shift    <= shift >> 1;
               count    <= '0;
               state    <= DATA;
            end
            DATA: begin
               if (count == LAST) begin
                  count <= '0;
                  if (par_en) begin
                     o_tx_out <= par_bit;
                     state    <= PARITY;
                  end else begin
                     o_tx_out <= 1'b1;
                     state    <= STOP;
                  end
               end else begin
                  o_tx_out <= shift[0];
                  shift    <= shift >> 1;
                  count    <= count + CW'(1);
               end
            end
            PARITY: begin
               o_tx_out <= 1'b1;
               state    <= STOP;
            end
            STOP: begin
               o_tx_out <= 1'b1;
               o_busy   <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               o_tx_out <= 1'b1;
               o_busy   <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: queue scoreboard fed by a frame-level model.
// Ports: none (drives DUT instances of width 8 and 7).
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data = '0;
   logic       valid = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       tx;
   logic       busy;

   logic [6:0] d7_data = '0;
   logic       d7_valid = 1'b0;
   logic       d7_par_en = 1'b0;
   logic       d7_par_typ = 1'b0;
   logic       d7_tx;
   logic       d7_busy;

   uart_tx_frame #(.DATA_WIDTH(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_data(data),
      .i_data_valid(valid), .i_par_en(par_en),
      .i_par_typ(par_typ), .o_tx_out(tx), .o_busy(busy)
   );

   uart_tx_frame #(.DATA_WIDTH(7)) dut7 (
      .i_clk(clk), .i_rst(rst), .i_data(d7_data),
      .i_data_valid(d7_valid), .i_par_en(d7_par_en),
      .i_par_typ(d7_par_typ), .o_tx_out(d7_tx), .o_busy(d7_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bits;
      int          len;
      int          k;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   next_free = 0;
   bit   mon_en = 1'b0;
   bit   in_frame = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Frame as a list of line levels, bit i = cycle i of the frame.
   function automatic exp_t model(input logic [7:0] d, input logic pe,
                                  input logic pt, input int k);
      exp_t e;
      int   ones = 0;
      int   n;
      e.bits = '0;
      e.bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         e.bits[1+i] = d[i];
         ones += int'(d[i]);
      end
      n = 9;
      if (pe) begin
         e.bits[n] = ((ones % 2) == 1) ^ pt;
         n++;
      end
      e.bits[n] = 1'b1;
      n++;
      e.len = n;
      e.k = k;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present inputs for one edge; the model decides whether it is accepted.
   task automatic drive(input logic [7:0] d, input logic pe, input logic pt, input logic v);
      exp_t e;
      data = d;
      par_en = pe;
      par_typ = pt;
      valid = v;
      if (v && (cyc + 1 >= next_free)) begin
         e = model(d, pe, pt, cyc + 1);
         q.push_back(e);
         next_free = cyc + 1 + e.len + 1;
      end
      tick();
   endtask

   task automatic send(input logic [7:0] d, input logic pe, input logic pt);
      valid = 1'b0;
      while (cyc + 1 < next_free) tick();
      drive(d, pe, pt, 1'b1);
      valid = 1'b0;
   endtask

   // Monitor: decodes frames from the line and checks them against the queue.
   initial begin : monitor
      exp_t        e;
      logic [15:0] act;
      int          idx;
      bit          have;
      idx = 0;
      have = 1'b0;
      act = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (!in_frame) begin
               if (busy) begin
                  in_frame = 1'b1;
                  act = '0;
                  act[0] = tx;
                  idx = 1;
                  tests++;
                  if (q.size() == 0) begin
                     fails++;
                     have = 1'b0;
                     $display("FAIL unexpected_frame: got start at cycle %0d expected none", cyc);
                  end else begin
                     e = q.pop_front();
                     have = 1'b1;
                     if (cyc != e.k) begin
                        fails++;
                        $display("FAIL start_cycle: got %0d expected %0d", cyc, e.k);
                     end
                  end
               end else begin
                  chk("idle_line", {31'd0, tx}, 32'd1);
               end
            end else if (busy) begin
               if (idx < 16) act[idx] = tx;
               idx++;
            end else begin
               in_frame = 1'b0;
               if (have) begin
                  chk("frame_bits", {16'd0, act}, {16'd0, e.bits});
                  chk("frame_len", idx, e.len);
               end
               chk("idle_after_stop", {31'd0, tx}, 32'd1);
            end
         end
      end
   end

   initial begin : stim
      bit          ok;
      logic [15:0] v7;
      int          n7;
      int          guard;

      repeat (3) tick();
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick();

      // Abort a frame of 0xFF in the middle of its data bits.
      valid = 1'b1;
      data = 8'hFF;
      tick();
      valid = 1'b0;
      repeat (4) tick();
      chk("pre_abort_busy", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_tx", {31'd0, tx}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      chk("post_abort_idle", {31'd0, ok}, 32'd1);

      mon_en = 1'b1;
      next_free = 0;

      send(8'hA5, 1'b0, 1'b0);
      send(8'hA5, 1'b1, 1'b0);
      send(8'hA5, 1'b1, 1'b1);
      send(8'h07, 1'b1, 1'b0);
      data = 8'h00;
      par_typ = 1'b1;
      repeat (3) tick();

      // Request while busy must be dropped.
      send(8'h11, 1'b0, 1'b0);
      repeat (2) tick();
      drive(8'h3C, 1'b0, 1'b0, 1'b1);
      valid = 1'b0;

      // Continuous valid: 0x55 then 0xAA, one idle cycle apart.
      while (cyc + 1 < next_free) tick();
      drive(8'h55, 1'b0, 1'b0, 1'b1);
      while (cyc + 1 < next_free) drive(8'hAA, 1'b0, 1'b0, 1'b1);
      drive(8'hAA, 1'b0, 1'b0, 1'b1);
      valid = 1'b0;

      for (int i = 0; i < 1500; i++) begin
         drive(8'($urandom), 1'($urandom), 1'($urandom),
               1'(($urandom % 4) == 0));
      end
      valid = 1'b0;

      guard = 0;
      while ((q.size() != 0 || in_frame || busy) && guard < 300) begin
         tick();
         guard++;
      end
      tick();
      chk("queue_drained", q.size(), 0);
      mon_en = 1'b0;

      // Seven-bit variant, 0x41 with odd parity.
      d7_data = 7'h41;
      d7_par_en = 1'b1;
      d7_par_typ = 1'b1;
      d7_valid = 1'b1;
      tick();
      d7_valid = 1'b0;
      d7_data = 7'h00;
      v7 = '0;
      n7 = 0;
      guard = 0;
      @(negedge clk);
      while (!d7_busy && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      while (d7_busy && n7 < 16) begin
         v7[n7] = d7_tx;
         n7++;
         @(negedge clk);
      end
      chk("w7_bits", {16'd0, v7}, 32'b1110000010);
      chk("w7_len", n7, 10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
